array_indirect_loader: RTL and testbench

- Upstream feeder for the nested-index array reader stage.
- Fills a DEPTH-entry register array from a valid/ready word stream.
- Then serves two-level indirect lookups: result = mem[ mem[addr][IDX_LSB+AW-1:IDX_LSB] ][OUT_W-1:0].
- The downstream consumer receives the resolved sub-field and the intermediate index over a valid/ready result port.

---
 rtl/array_indirect_loader.sv | 93 +++++++++
 tb/tb_array_indirect_loader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/array_indirect_loader.sv
// Loads a small register array from a word stream, then serves
// two-level indirect lookups over a valid/ready result port.
module array_indirect_loader #(
    parameter int WIDTH   = 3,
    parameter int DEPTH   = 4,
    parameter int AW      = 2,
    parameter int IDX_LSB = 1,
    parameter int OUT_W   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             loaded,
    input  logic             lk_valid,
    input  logic [AW-1:0]    lk_addr,
    output logic             lk_ready,
    output logic             res_valid,
    output logic [OUT_W-1:0] res_data,
    output logic [AW-1:0]    res_index,
    input  logic             res_ready
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] READY  = 3'd2;
    localparam logic [2:0] LOOK   = 3'd3;
    localparam logic [2:0] RESULT = 3'd4;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [2:0]       r_state;
    logic [AW-1:0]    r_wptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [OUT_W-1:0] r_res_data;
    logic [AW-1:0]    r_res_index;

    // Handshake and status outputs decode from state alone.
    assign in_ready  = (r_state == LOAD);
    assign lk_ready  = (r_state == READY);
    assign res_valid = (r_state == RESULT);
    assign loaded    = (r_state == READY) || (r_state == LOOK)
                    || (r_state == RESULT);
    assign res_data  = r_res_data;
    assign res_index = r_res_index;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_wptr      <= '0;
            r_res_data  <= '0;
            r_res_index <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (start) begin
            // Restart drops any in-flight work; the array keeps its contents.
            r_state <= LOAD;
            r_wptr  <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (in_valid) begin
                        r_mem[r_wptr] <= in_data;
                        r_wptr        <= r_wptr + 1'b1;
                        if (r_wptr == LAST) begin
                            r_state <= READY;
                        end
                    end
                end
                READY: begin
                    if (lk_valid) begin
                        r_res_index <= r_mem[lk_addr][IDX_LSB +: AW];
                        r_state     <= LOOK;
                    end
                end
                LOOK: begin
                    r_res_data <= r_mem[r_res_index][OUT_W-1:0];
                    r_state    <= RESULT;
                end
                RESULT: begin
                    if (res_ready) begin
                        r_state <= READY;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

endmodule

// File: tb/tb_array_indirect_loader.sv
// Directed bench for array_indirect_loader with hand-computed
// expected load, lookup, hold, restart and reset behaviour.
module tb_array_indirect_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic [2:0] in_data;
    logic       in_ready;
    logic       loaded;
    logic       lk_valid;
    logic [1:0] lk_addr;
    logic       lk_ready;
    logic       res_valid;
    logic [1:0] res_data;
    logic [1:0] res_index;
    logic       res_ready;

    int n_chk = 0;
    int n_fail = 0;

    array_indirect_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .loaded    (loaded),
        .lk_valid  (lk_valid),
        .lk_addr   (lk_addr),
        .lk_ready  (lk_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_index (res_index),
        .res_ready (res_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Words are packed w0 in the low bits.
    task automatic load4(input logic [11:0] words);
        for (int i = 0; i < 4; i++) begin
            chk("load_in_ready", in_ready, 1);
            chk("load_not_loaded", loaded, 0);
            in_valid = 1'b1;
            in_data  = words[i*3 +: 3];
            tick();
        end
        in_valid = 1'b0;
        chk("loaded_after4", loaded, 1);
        chk("lk_ready_after4", lk_ready, 1);
        chk("in_ready_after4", in_ready, 0);
    endtask

    task automatic lookup(input logic [1:0] a, input logic [1:0] e_idx,
                          input logic [1:0] e_dat);
        chk("lk_ready_pre", lk_ready, 1);
        lk_valid  = 1'b1;
        lk_addr   = a;
        res_ready = 1'b1;
        tick();
        lk_valid = 1'b0;
        chk("lk_ready_look", lk_ready, 0);
        chk("res_valid_1edge", res_valid, 0);
        tick();
        chk("res_valid_2edge", res_valid, 1);
        chk("res_index", res_index, e_idx);
        chk("res_data", res_data, e_dat);
        chk("lk_ready_result", lk_ready, 0);
        tick();
        res_ready = 1'b0;
        chk("res_valid_done", res_valid, 0);
        chk("lk_ready_again", lk_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        lk_valid = 1'b0; lk_addr = '0; res_ready = 1'b0;
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_loaded", loaded, 0);
        chk("rst_lk_ready", lk_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_index", res_index, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_in_ready", in_ready, 0);

        // Load 010,101,110,011 -> indices 1,2,3,1 and data fields.
        pulse_start();
        load4({3'b011, 3'b110, 3'b101, 3'b010});
        lookup(2'd0, 2'd1, 2'b01);
        lookup(2'd1, 2'd2, 2'b10);
        lookup(2'd2, 2'd3, 2'b11);
        lookup(2'd3, 2'd1, 2'b01);

        // Backpressure: result held, further lookups refused.
        lk_valid = 1'b1; lk_addr = 2'd2;
        tick();
        tick();
        lk_addr = 2'd0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", res_valid, 1);
            chk("hold_data", res_data, 2'b11);
            chk("hold_index", res_index, 2'd3);
            chk("hold_lk_ready", lk_ready, 0);
            tick();
        end
        lk_valid  = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("hold_released", res_valid, 0);
        chk("hold_lk_ready_back", lk_ready, 1);
        chk("hold_index_kept", res_index, 2'd3);

        // Gapped load of 001,100,010,111.
        pulse_start();
        begin
            logic [6:0]  vpat;
            logic [11:0] wds;
            int k;
            vpat = 7'b1011001;
            wds  = {3'b111, 3'b010, 3'b100, 3'b001};
            k = 0;
            for (int i = 0; i < 7; i++) begin
                chk("gap_not_loaded", loaded, 0);
                in_valid = vpat[i];
                in_data  = vpat[i] ? wds[k*3 +: 3] : 3'b000;
                if (vpat[i]) k++;
                tick();
            end
            in_valid = 1'b0;
        end
        chk("gap_loaded", loaded, 1);
        lookup(2'd0, 2'd0, 2'b01);
        lookup(2'd1, 2'd2, 2'b10);
        lookup(2'd3, 2'd3, 2'b11);

        // Restart during LOOK drops the lookup.
        lk_valid = 1'b1; lk_addr = 2'd1; res_ready = 1'b1;
        tick();
        lk_valid = 1'b0;
        pulse_start();
        chk("rs_res_valid", res_valid, 0);
        chk("rs_loaded", loaded, 0);
        chk("rs_in_ready", in_ready, 1);
        res_ready = 1'b0;
        load4({3'b000, 3'b000, 3'b000, 3'b111});
        lookup(2'd0, 2'd3, 2'b00);

        // Reset mid-load after two words.
        pulse_start();
        in_valid = 1'b1; in_data = 3'b101;
        tick();
        in_data = 3'b110;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_loaded", loaded, 0);
        chk("mid_rst_res_index", res_index, 0);
        chk("mid_rst_res_data", res_data, 0);
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 3'b111;
        tick();
        in_valid = 1'b0;
        chk("post_rst_idle", in_ready, 0);
        chk("post_rst_loaded", loaded, 0);
        pulse_start();
        load4({3'b000, 3'b010, 3'b100, 3'b001});
        lookup(2'd1, 2'd2, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
